// File: rtl/serial_add_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : serial_add_ctrl
// Description : Bit-serial adder sequencer. One full-adder cell (two half
//               adders plus an OR) is stepped LSB-first over WIDTH cycles,
//               with the carry held in a single flop. The result is presented
//               on registered Sum/Cout together with a one-cycle Done pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_load;

   logic [WIDTH-1:0]   r_opa;
   logic [WIDTH-1:0]   r_opb;
   logic [WIDTH-1:0]   r_acc;
   logic               r_carry;
   logic [c_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;

   // Full-adder cell built from two half adders and an OR.
   logic               w_ha1_s;
   logic               w_ha1_c;
   logic               w_ha2_c;
   logic               w_s;
   logic               w_c;
   logic               w_last;
   logic [WIDTH-1:0]   w_acc_nxt;

   assign w_ha1_s = r_opa[0] ^ r_opb[0];
   assign w_ha1_c = r_opa[0] & r_opb[0];
   assign w_s     = w_ha1_s ^ r_carry;
   assign w_ha2_c = w_ha1_s & r_carry;
   assign w_c     = w_ha1_c | w_ha2_c;

   // New sum bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
   assign w_acc_nxt = {w_s, {(WIDTH-1){1'b0}}} | (r_acc >> 1);
   assign w_last    = (r_cnt == c_CNT_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a start is accepted only in IDLE or DONE.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_ADD;
            end
         end
         ST_ADD: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_ADD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath: operand load, serial stepping, and result capture on the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opa   <= '0;
         r_opb   <= '0;
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_load) begin
         r_opa   <= a;
         r_opb   <= b;
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (r_state == ST_ADD) begin
         r_opa   <= r_opa >> 1;
         r_opb   <= r_opb >> 1;
         r_acc   <= w_acc_nxt;
         r_carry <= w_c;
         r_cnt   <= r_cnt + c_CNT_ONE;
         if (w_last) begin
            r_sum  <= w_acc_nxt;
            r_cout <= w_c;
         end
      end
   end

   // Moore outputs decoded straight from the state register.
   assign busy = (r_state == ST_ADD);
   assign done = (r_state == ST_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl at WIDTH=8 and 16.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_serial_add_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [7:0]  sum;
   logic        cout;

   logic        start16;
   logic [15:0] a16;
   logic [15:0] b16;
   logic        busy16;
   logic        done16;
   logic [15:0] sum16;
   logic        cout16;

   int n_total;
   int n_bad;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   serial_add_ctrl #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start16),
      .a     (a16),
      .b     (b16),
      .busy  (busy16),
      .done  (done16),
      .sum   (sum16),
      .cout  (cout16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench.
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One 8-bit operation with full timing checks: busy for 8 edges, then one done cycle.
   task automatic run8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] exp_sum, input logic exp_cout);
      int busy_err;
      busy_err = 0;
      start = 1'b1; a = ia; b = ib;
      tick();
      start = 1'b0; a = 8'hxx; b = 8'hxx;
      for (int i = 0; i < 8; i++) begin
         if (busy !== 1'b1 || done !== 1'b0) busy_err++;
         tick();
      end
      chk({tag, "_busywin"}, 64'(busy_err), 64'd0);
      chk({tag, "_done"}, {62'd0, busy, done}, 64'b01);
      chk({tag, "_sum"}, 64'(sum), 64'(exp_sum));
      chk({tag, "_cout"}, 64'(cout), 64'(exp_cout));
      tick();
      chk({tag, "_done_off"}, 64'(done), 64'd0);
      chk({tag, "_hold"}, {55'd0, cout, sum}, {55'd0, exp_cout, exp_sum});
   endtask

   // 16-bit operation; waits for done with a bounded budget.
   task automatic run16(input logic [15:0] ia, input logic [15:0] ib);
      int n;
      logic [16:0] exp;
      exp = {1'b0, ia} + {1'b0, ib};
      start16 = 1'b1; a16 = ia; b16 = ib;
      tick();
      start16 = 1'b0;
      n = 0;
      while (done16 !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("r16_latency", 64'(n), 64'd16);
      chk("r16_result", {47'd0, cout16, sum16}, {47'd0, exp});
   endtask

   initial begin
      int rst_err;
      logic [8:0] exp9;
      logic [7:0] ra;
      logic [7:0] rb;
      n_total = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      start   = 1'b0; a = 8'h00; b = 8'h00;
      start16 = 1'b0; a16 = 16'h0; b16 = 16'h0;

      // Reset values with clock running.
      repeat (3) tick();
      chk("rst_outputs", {52'd0, busy, done, cout, sum}, 64'd0);
      #2 rst_n = 1'b1;
      repeat (3) tick();
      chk("rst_idle", {52'd0, busy, done, cout, sum}, 64'd0);

      // Directed vectors.
      run8("basic",   8'h05, 8'h03, 8'h08, 1'b0);
      run8("carry1",  8'hFF, 8'h01, 8'h00, 1'b1);
      run8("zero",    8'h00, 8'h00, 8'h00, 1'b0);

      // Start while busy is ignored.
      start = 1'b1; a = 8'h10; b = 8'h20;
      tick();
      start = 1'b0;
      repeat (3) tick();
      start = 1'b1; a = 8'hAA; b = 8'h55;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("ign_done", {62'd0, busy, done}, 64'b01);
      chk("ign_sum", {55'd0, cout, sum}, {55'd0, 1'b0, 8'h30});
      tick();
      chk("ign_idle", {62'd0, busy, done}, 64'd0);

      // Back-to-back with start held high.
      start = 1'b1; a = 8'h7F; b = 8'h01;
      tick();
      repeat (8) tick();
      chk("b2b_done1", {62'd0, busy, done}, 64'b01);
      chk("b2b_sum1", {55'd0, cout, sum}, {55'd0, 1'b0, 8'h80});
      a = 8'h80; b = 8'h80;
      tick();
      chk("b2b_reaccept", {62'd0, busy, done}, 64'b10);
      start = 1'b0;
      repeat (7) tick();
      chk("b2b_gap", {62'd0, busy, done}, 64'b10);
      tick();
      chk("b2b_done2", {62'd0, busy, done}, 64'b01);
      chk("b2b_sum2", {55'd0, cout, sum}, {55'd0, 1'b1, 8'h00});
      tick();

      run8("carryff", 8'hFF, 8'hFF, 8'hFE, 1'b1);

      // Reset mid-operation: outputs clear immediately, no done afterwards.
      start = 1'b1; a = 8'h0F; b = 8'h0F;
      tick();
      start = 1'b0;
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_now", {52'd0, busy, done, cout, sum}, 64'd0);
      rst_err = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0) rst_err++;
      end
      #2 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0) rst_err++;
      end
      chk("midrst_nodone", 64'(rst_err), 64'd0);
      run8("postrst", 8'h01, 8'h02, 8'h03, 1'b0);

      // Scoreboard sweeps.
      for (int i = 0; i < 500; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         exp9 = {1'b0, ra} + {1'b0, rb};
         run8("r8", ra, rb, exp9[7:0], exp9[8]);
      end
      for (int i = 0; i < 500; i++) begin
         run16(16'($urandom), 16'($urandom));
      end
      run16(16'hFFFF, 16'h0001);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
